// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write-port scheduler.
//   FB_XW/FB_YW/FB_CW : default cell-coordinate and colour widths
//   X_LSB/Y_LSB/C_LSB : field positions inside the packed CPU store word
//   fill_state_e      : rectangle-fill FSM encoding
//   grant_e           : arbiter grant identity (also the last_grant record)
package fb_pkg;
  localparam int FB_XW = 6;
  localparam int FB_YW = 6;
  localparam int FB_CW = 3;

  localparam int X_LSB = 8;
  localparam int Y_LSB = 0;
  localparam int C_LSB = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_FILL = 1'b1
  } grant_e;
endpackage

// File: rtl/fb_write_sched_if.sv
// Bus bundle between the CPU store path / fill command source and the
// framebuffer port-A write inputs.
//   master : drives CPU stores and fill commands, observes status and fb_*
//   slave  : the scheduler; returns cpu_ready, fill status and fb_addr/din/we
interface fb_write_sched_if
  #(parameter int XW = fb_pkg::FB_XW,
    parameter int YW = fb_pkg::FB_YW,
    parameter int CW = fb_pkg::FB_CW);

  logic             cpu_we;
  logic [31:0]      cpu_data;
  logic             cpu_ready;
  logic             fill_start;
  logic [XW-1:0]    fill_x0;
  logic [XW-1:0]    fill_x1;
  logic [YW-1:0]    fill_y0;
  logic [YW-1:0]    fill_y1;
  logic [CW-1:0]    fill_color;
  logic             fill_abort;
  logic             fill_busy;
  logic             fill_done;
  logic [XW+YW-1:0] fb_addr;
  logic [CW-1:0]    fb_din;
  logic             fb_we;

  modport master (
    output cpu_we, cpu_data, fill_start, fill_x0, fill_x1, fill_y0, fill_y1,
           fill_color, fill_abort,
    input  cpu_ready, fill_busy, fill_done, fb_addr, fb_din, fb_we
  );

  modport slave (
    input  cpu_we, cpu_data, fill_start, fill_x0, fill_x1, fill_y0, fill_y1,
           fill_color, fill_abort,
    output cpu_ready, fill_busy, fill_done, fb_addr, fb_din, fb_we
  );
endinterface

// File: rtl/fb_fill_walker.sv
// Rectangle-fill engine: latches a fill command, walks the cursor row-major
// over the inclusive rectangle, one cell per grant.
//   clk_i, rst_n_i        : clock, async active-low reset
//   start_i, abort_i      : command strobe (IDLE only) / cancel (FILL only)
//   x0_i..y1_i, color_i   : inclusive bounds and colour
//   grant_i               : arbiter accepted the current cursor cell
//   req_o, busy_o         : write request / FILL state indicator
//   cx_o, cy_o, color_o   : current cell and colour to write
//   done_o                : one-cycle completion pulse
//
// state   | meaning
// --------+----------------------------------------------------
// ST_IDLE | waiting for start_i; empty rectangles complete here
// ST_FILL | requesting a write every cycle at (cx, cy)
module fb_fill_walker
  import fb_pkg::*;
#(
  parameter int XW = FB_XW,
  parameter int YW = FB_YW,
  parameter int CW = FB_CW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [XW-1:0] x0_i,
  input  logic [XW-1:0] x1_i,
  input  logic [YW-1:0] y0_i,
  input  logic [YW-1:0] y1_i,
  input  logic [CW-1:0] color_i,
  input  logic          grant_i,
  output logic          req_o,
  output logic          busy_o,
  output logic [XW-1:0] cx_o,
  output logic [YW-1:0] cy_o,
  output logic [CW-1:0] color_o,
  output logic          done_o
);

  fill_state_e   state_q, state_d;
  logic [XW-1:0] cx_q, cx_d, x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0] cy_q, cy_d, y1_q, y1_d;
  logic [CW-1:0] color_q, color_d;
  logic          done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          x0_d    = x0_i;
          x1_d    = x1_i;
          y1_d    = y1_i;
          color_d = color_i;
          cx_d    = x0_i;
          cy_d    = y0_i;
          // An empty rectangle completes without ever requesting the port.
          if ((x0_i > x1_i) || (y0_i > y1_i)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        // Abort wins over a same-cycle grant; that granted write still lands
        // because the top-level output register has already captured it.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (grant_i) begin
          // Termination is by equality compare so x1/y1 = max never wraps.
          if (cx_q == x1_q) begin
            if (cy_q == y1_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              cx_d = x0_q;
              cy_d = cy_q + YW'(1);
            end
          end else begin
            cx_d = cx_q + XW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_o   = (state_q == ST_FILL);
  assign busy_o  = (state_q == ST_FILL);
  assign cx_o    = cx_q;
  assign cy_o    = cy_q;
  assign color_o = color_q;
  assign done_o  = done_q;

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: shares the single port-A write path
// between CPU single-cell stores (1-deep holding register) and the
// rectangle-fill walker, round-robin, one write per cycle, registered output.
//   clka, reset_n : clock, async active-low reset
//   bus (slave)   : CPU store handshake, fill command/status, fb_addr/din/we
// XW/YW/CW must match the parameters of the connected interface instance.
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int XW = FB_XW,
  parameter int YW = FB_YW,
  parameter int CW = FB_CW
) (
  input  logic            clka,
  input  logic            reset_n,
  fb_write_sched_if.slave bus
);

  logic             hv_q, hv_d;
  logic [XW-1:0]    hx_q, hx_d;
  logic [YW-1:0]    hy_q, hy_d;
  logic [CW-1:0]    hc_q, hc_d;
  grant_e           last_grant_q, last_grant_d;

  logic [XW+YW-1:0] addr_q, addr_d;
  logic [CW-1:0]    din_q, din_d;
  logic             we_q, we_d;

  logic             fill_req, cpu_grant, fill_grant, cpu_ready, accept;
  logic [XW-1:0]    fill_cx;
  logic [YW-1:0]    fill_cy;
  logic [CW-1:0]    fill_color;

  fb_fill_walker #(.XW(XW), .YW(YW), .CW(CW)) u_walker (
    .clk_i   (clka),
    .rst_n_i (reset_n),
    .start_i (bus.fill_start),
    .abort_i (bus.fill_abort),
    .x0_i    (bus.fill_x0),
    .x1_i    (bus.fill_x1),
    .y0_i    (bus.fill_y0),
    .y1_i    (bus.fill_y1),
    .color_i (bus.fill_color),
    .grant_i (fill_grant),
    .req_o   (fill_req),
    .busy_o  (bus.fill_busy),
    .cx_o    (fill_cx),
    .cy_o    (fill_cy),
    .color_o (fill_color),
    .done_o  (bus.fill_done)
  );

  // Round-robin between two requesters: on contention the one that did not
  // win last time is granted.
  assign cpu_grant  = hv_q && (!fill_req || (last_grant_q == GRANT_FILL));
  assign fill_grant = fill_req && !cpu_grant;

  // The holding register can reload on the same edge it drains.
  assign cpu_ready = !hv_q || cpu_grant;
  assign accept    = bus.cpu_we && cpu_ready;

  always_comb begin
    hv_d         = hv_q;
    hx_d         = hx_q;
    hy_d         = hy_q;
    hc_d         = hc_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    din_d        = din_q;
    we_d         = 1'b0;

    if (accept) begin
      hv_d = 1'b1;
      hx_d = bus.cpu_data[X_LSB +: XW];
      hy_d = bus.cpu_data[Y_LSB +: YW];
      hc_d = bus.cpu_data[C_LSB +: CW];
    end else if (cpu_grant) begin
      hv_d = 1'b0;
    end

    if (cpu_grant) begin
      last_grant_d = GRANT_CPU;
      addr_d       = {hx_q, hy_q};
      din_d        = hc_q;
      we_d         = 1'b1;
    end else if (fill_grant) begin
      last_grant_d = GRANT_FILL;
      addr_d       = {fill_cx, fill_cy};
      din_d        = fill_color;
      we_d         = 1'b1;
    end
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      hv_q         <= 1'b0;
      hx_q         <= '0;
      hy_q         <= '0;
      hc_q         <= '0;
      last_grant_q <= GRANT_FILL;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
    end else begin
      hv_q         <= hv_d;
      hx_q         <= hx_d;
      hy_q         <= hy_d;
      hc_q         <= hc_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      we_q         <= we_d;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.fb_addr   = addr_q;
  assign bus.fb_din    = din_q;
  assign bus.fb_we     = we_q;

endmodule

// File: tb/tb_fb_write_sched.sv
module tb_fb_write_sched;
  import fb_pkg::*;

  logic clka = 1'b0;
  logic reset_n = 1'b0;
  always #5 clka = ~clka;

  fb_write_sched_if bus ();

  fb_write_sched dut (
    .clka    (clka),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves time at posedge+1: registered outputs settled, inputs may be driven.
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [11:0] addr;
    logic [2:0]  din;
  } cpu_vec_t;

  typedef struct {
    int x0, x1, y0, y1, color;
    int writes;
  } fill_vec_t;

  cpu_vec_t  cv[5];
  fill_vec_t fv[5];

  int ex, ey, wr, busy_cnt, dcnt, dcyc, ci;
  logic [31:0] cw[4];
  logic [11:0] xa[8];
  logic [2:0]  xd[8];

  initial begin
    cv[0] = '{32'h0005_0A03, 12'h283, 3'd5};
    cv[1] = '{32'hFFFF_FFFF, 12'hFFF, 3'd7};
    cv[2] = '{32'h0002_3F00, 12'hFC0, 3'd2};
    cv[3] = '{32'hFFF8_C0C0, 12'h000, 3'd0};
    cv[4] = '{32'h0004_2A15, 12'hA95, 3'd4};

    fv[0] = '{2, 4, 7, 8, 3, 6};
    fv[1] = '{5, 4, 0, 0, 1, 0};
    fv[2] = '{0, 0, 9, 3, 2, 0};
    fv[3] = '{60, 63, 62, 63, 6, 8};
    fv[4] = '{7, 7, 7, 7, 5, 1};

    bus.cpu_we = 0; bus.cpu_data = '0; bus.fill_start = 0; bus.fill_abort = 0;
    bus.fill_x0 = '0; bus.fill_x1 = '0; bus.fill_y0 = '0; bus.fill_y1 = '0;
    bus.fill_color = '0;

    // Reset values
    #2;
    check("rst_fb_we", 32'(bus.fb_we), 0);
    check("rst_fb_addr", 32'(bus.fb_addr), 0);
    check("rst_fb_din", 32'(bus.fb_din), 0);
    check("rst_busy", 32'(bus.fill_busy), 0);
    check("rst_done", 32'(bus.fill_done), 0);
    check("rst_ready", 32'(bus.cpu_ready), 1);
    @(negedge clka); @(negedge clka);
    reset_n = 1'b1;
    tick();

    // Single CPU stores, uncontended
    for (int v = 0; v < 5; v++) begin
      bus.cpu_we = 1; bus.cpu_data = cv[v].data;
      #1;
      check($sformatf("cpu%0d_ready", v), 32'(bus.cpu_ready), 1);
      tick();
      bus.cpu_we = 0;
      check($sformatf("cpu%0d_we_c1", v), 32'(bus.fb_we), 0);
      check($sformatf("cpu%0d_ready_c1", v), 32'(bus.cpu_ready), 1);
      tick();
      check($sformatf("cpu%0d_we_c2", v), 32'(bus.fb_we), 1);
      check($sformatf("cpu%0d_addr", v), 32'(bus.fb_addr), 32'(cv[v].addr));
      check($sformatf("cpu%0d_din", v), 32'(bus.fb_din), 32'(cv[v].din));
      tick();
      check($sformatf("cpu%0d_we_c3", v), 32'(bus.fb_we), 0);
    end

    // Back-to-back CPU stores sustain one per cycle
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        bus.cpu_we = 1; bus.cpu_data = cv[k].data;
      end else begin
        bus.cpu_we = 0;
      end
      #1;
      if (k < 3) check($sformatf("b2b_ready%0d", k), 32'(bus.cpu_ready), 1);
      if (k >= 2) begin
        check($sformatf("b2b_we%0d", k), 32'(bus.fb_we), 1);
        check($sformatf("b2b_addr%0d", k), 32'(bus.fb_addr), 32'(cv[k-2].addr));
      end
      tick();
    end
    tick();

    // Fill rectangles, including empty and edge-of-grid cases
    for (int v = 0; v < 5; v++) begin
      bus.fill_x0 = 6'(fv[v].x0); bus.fill_x1 = 6'(fv[v].x1);
      bus.fill_y0 = 6'(fv[v].y0); bus.fill_y1 = 6'(fv[v].y1);
      bus.fill_color = 3'(fv[v].color); bus.fill_start = 1;
      tick();
      bus.fill_start = 0;
      ex = fv[v].x0; ey = fv[v].y0; wr = 0; busy_cnt = 0; dcnt = 0; dcyc = -1;
      for (int k = 1; k <= fv[v].writes + 4; k++) begin
        if (bus.fb_we) begin
          check($sformatf("fill%0d_addr%0d", v, wr), 32'(bus.fb_addr), 32'((ex << 6) | ey));
          check($sformatf("fill%0d_din%0d", v, wr), 32'(bus.fb_din), 32'(fv[v].color));
          check($sformatf("fill%0d_cyc%0d", v, wr), 32'(k), 32'(wr + 2));
          wr++;
          if (ex == fv[v].x1) begin ex = fv[v].x0; ey++; end
          else ex++;
        end
        if (bus.fill_busy) busy_cnt++;
        if (bus.fill_done) begin dcnt++; dcyc = k; end
        tick();
      end
      check($sformatf("fill%0d_writes", v), 32'(wr), 32'(fv[v].writes));
      check($sformatf("fill%0d_busy", v), 32'(busy_cnt), 32'(fv[v].writes));
      check($sformatf("fill%0d_done_cnt", v), 32'(dcnt), 1);
      check($sformatf("fill%0d_done_cyc", v), 32'(dcyc),
            32'((fv[v].writes == 0) ? 1 : fv[v].writes + 1));
    end

    // Contention: CPU and fill alternate, fb_we every cycle
    for (int i = 0; i < 4; i++) begin
      cw[i] = 32'(((i + 1) << 16) | ((10 + i) << 8) | 20);
      xa[2*i]   = 12'(((10 + i) << 6) | 20);
      xd[2*i]   = 3'(i + 1);
      xa[2*i+1] = 12'((i << 6) | 5);
      xd[2*i+1] = 3'd6;
    end
    ci = 0; wr = 0; dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        bus.fill_x0 = 6'd0; bus.fill_x1 = 6'd3; bus.fill_y0 = 6'd5; bus.fill_y1 = 6'd5;
        bus.fill_color = 3'd6; bus.fill_start = 1;
      end else begin
        bus.fill_start = 0;
      end
      if (ci < 4) begin bus.cpu_we = 1; bus.cpu_data = cw[ci]; end
      else bus.cpu_we = 0;
      #1;
      if (c <= 7)
        check($sformatf("cont_ready%0d", c), 32'(bus.cpu_ready), 32'((c == 0) || (c % 2 == 1)));
      if (bus.cpu_we && bus.cpu_ready) ci++;
      if (bus.fb_we) begin
        if (wr < 8) begin
          check($sformatf("cont_addr%0d", wr), 32'(bus.fb_addr), 32'(xa[wr]));
          check($sformatf("cont_din%0d", wr), 32'(bus.fb_din), 32'(xd[wr]));
        end
        check($sformatf("cont_cyc%0d", wr), 32'(c), 32'(wr + 2));
        wr++;
      end
      if (bus.fill_done) begin
        dcnt++;
        check("cont_done_cyc", 32'(c), 9);
      end
      tick();
    end
    check("cont_writes", 32'(wr), 8);
    check("cont_done_cnt", 32'(dcnt), 1);
    check("cont_cpu_accepted", 32'(ci), 4);

    // Abort on 3rd FILL cycle of a full-grid fill, then immediate restart
    wr = 0; dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      bus.fill_start = 0; bus.fill_abort = 0;
      if (c == 0) begin
        bus.fill_x0 = 6'd0; bus.fill_x1 = 6'd63; bus.fill_y0 = 6'd0; bus.fill_y1 = 6'd63;
        bus.fill_color = 3'd1; bus.fill_start = 1;
      end
      if (c == 3) bus.fill_abort = 1;
      if (c == 4) begin
        bus.fill_x0 = 6'd1; bus.fill_x1 = 6'd1; bus.fill_y0 = 6'd2; bus.fill_y1 = 6'd2;
        bus.fill_color = 3'd7; bus.fill_start = 1;
      end
      #1;
      if (c >= 1 && c <= 5 && bus.fb_we) begin
        check($sformatf("abort_addr%0d", wr), 32'(bus.fb_addr), 32'(wr << 6));
        wr++;
      end
      if (c >= 1 && c <= 5 && bus.fill_done) dcnt++;
      if (c == 4) check("abort_idle", 32'(bus.fill_busy), 0);
      if (c == 5) check("restart_busy", 32'(bus.fill_busy), 1);
      if (c == 6) begin
        check("restart_we", 32'(bus.fb_we), 1);
        check("restart_addr", 32'(bus.fb_addr), 32'((1 << 6) | 2));
        check("restart_din", 32'(bus.fb_din), 7);
        check("restart_done", 32'(bus.fill_done), 1);
      end
      tick();
    end
    bus.fill_start = 0; bus.fill_abort = 0;
    check("abort_writes", 32'(wr), 3);
    check("abort_no_done", 32'(dcnt), 0);

    // Async reset mid-fill with a pending CPU store
    bus.fill_x0 = 6'd0; bus.fill_x1 = 6'd63; bus.fill_y0 = 6'd0; bus.fill_y1 = 6'd63;
    bus.fill_color = 3'd4; bus.fill_start = 1;
    tick();
    bus.fill_start = 0;
    bus.cpu_we = 1; bus.cpu_data = 32'h0001_0101;
    tick();
    bus.cpu_we = 0;
    check("prereset_we", 32'(bus.fb_we), 1);
    check("prereset_busy", 32'(bus.fill_busy), 1);
    reset_n = 1'b0;
    #1;
    check("arst_we", 32'(bus.fb_we), 0);
    check("arst_addr", 32'(bus.fb_addr), 0);
    check("arst_din", 32'(bus.fb_din), 0);
    check("arst_busy", 32'(bus.fill_busy), 0);
    check("arst_ready", 32'(bus.cpu_ready), 1);
    @(negedge clka); @(negedge clka);
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("post_rst_we%0d", k), 32'(bus.fb_we), 0);
      check($sformatf("post_rst_busy%0d", k), 32'(bus.fill_busy), 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
- Write-port scheduler for the 64x64-cell, 3-bit-colour VGA framebuffer.
- Shares the single framebuffer write port between two requesters:
  - CPU single-cell stores, using the packed 32-bit store word.
  - A hardware rectangle-fill engine.
- Sits between the CPU store path and the framebuffer port-A inputs (addr, din, we).
- Arbitration is round-robin, one write per cycle.

Parameters:
XW, 6, x cell-coordinate width
YW, 6, y cell-coordinate width
CW, 3, colour width

Ports:
clka  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cpu_we  in  1  CPU store request
cpu_data  in  32  packed store word: x=[13:8], y=[5:0], colour=[18:16]; other bits ignored
cpu_ready  out  1  store accepted when cpu_we&&cpu_ready
fill_start  in  1  fill command strobe, honoured only in IDLE
fill_x0,fill_x1  in  XW  inclusive column bounds
fill_y0,fill_y1  in  YW  inclusive row bounds
fill_color  in  CW  fill colour
fill_abort  in  1  cancel an active fill
fill_busy  out  1  high in FILL state
fill_done  out  1  one-cycle completion pulse
fb_addr  out  XW+YW  {x,y}, x in MSBs, matching framebuffer port-A order
fb_din  out  CW  write colour
fb_we  out  1  write enable

Behaviour:
Reset (async assert, sync deassert use):
- All outputs 0, except cpu_ready=1.
- State IDLE, CPU holding register empty, last_grant=FILL (CPU wins the first contention).

CPU path:
- 1-deep holding register (hx, hy, hc, hv).
- cpu_ready = !hv || grant_cpu (combinational).
- Accepting while draining loads the new word the same edge, so back-to-back stores sustain 1/cycle when uncontended.
- cpu_we while !cpu_ready is ignored; the CPU must hold it.

Fill FSM, states IDLE, FILL:
- IDLE + fill_start:
  - Latch bounds and colour.
  - If x0>x1 or y0>y1: stay IDLE, pulse fill_done the next cycle, zero writes.
  - Otherwise go to FILL with cursor cx=x0, cy=y0.
- FILL:
  - Fill requests every cycle.
  - On each fill grant, advance the cursor row-major: cx++; when cx==x1, set cx=x0 and cy++.
  - The grant at (x1,y1) returns to IDLE and pulses fill_done the next cycle (the same cycle as the last fb_we).
- fill_abort in FILL: IDLE next edge, no fill_done, the in-flight granted write still completes. Ignored in IDLE.
- fill_start in FILL is ignored.
- Cursor arithmetic is XW/YW wide. x1=63 or y1=63 terminates by comparison, never by wrap.

Arbiter:
- Requesters: hv and (state==FILL).
- Only one pending: it wins.
- Both pending: grant whichever is not last_grant; last_grant updates on every grant.
- Result under contention: strict alternation, CPU:fill = 1:1.

Output register:
- Granted {x,y,colour} registered into fb_addr/fb_din; fb_we=1 the next cycle, else fb_we=0 and addr/din hold.
- Latency:
  - CPU: accept at cycle n, fb_we at n+2 when uncontended.
  - Fill: fill_start at n, first fb_we at n+2.
- Writes to the same cell from both sources commit in grant order.

Decomposition:
- Shared package fb_pkg holds:
  - XW/YW/CW defaults.
  - Store-word field positions (X_LSB=8, Y_LSB=0, C_LSB=16).
  - FSM state encoding.
  - The GRANT_CPU/GRANT_FILL constant.
- One natural sub-module: fb_fill_walker (cursor, bounds, FSM; req/grant handshake).
- Arbiter and output register stay in the top level.

Test Plan:
- Reset then cpu_we, cpu_data=0x0005_0A03 at cycle 0 -> fb_we=1 at cycle 2 with fb_addr={6'd10,6'd3}, fb_din=5; cpu_ready stays 1.
- fill_start x0=2,x1=4,y0=7,y1=8, colour=3, no CPU traffic -> 6 consecutive fb_we in order (2,7),(3,7),(4,7),(2,8),(3,8),(4,8); fill_busy high 6 cycles; fill_done coincident with the 6th write.
- Fill active plus continuous cpu_we -> fb_we every cycle, sources alternating CPU/fill; cpu_ready toggles 1/0; total cycles = CPU count + fill count.
- fill_start x0=5,x1=4 -> fill_done pulse 1 cycle later, zero fb_we, fill_busy never high.
- fill_abort on the 3rd FILL cycle of a 64x64 fill (0..63) -> exactly 3 fill writes, FSM IDLE, no fill_done; a new fill_start is accepted the next cycle.
- reset_n asserted mid-fill with hv=1 -> outputs cleared immediately (asynchronously), pending CPU write discarded, no fb_we after release until new requests.
